// File: rtl/axil_lb_bridge_pkg.sv
// axil_lb_pkg: shared FSM state type and AXI response constants for the AXI-Lite to local-bus bridge
package axil_lb_pkg;
    typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RWAIT, RRESP} state_t;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/axil_lb_bridge_if.sv
// axil_lb_bridge_if: AXI4-Lite slave channels plus local-bus initiator signals of one register bank
interface axil_lb_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH+1:0]   s_awaddr;
    logic                    s_awvalid;
    logic                    s_awready;
    logic [DATA_WIDTH-1:0]   s_wdata;
    logic [DATA_WIDTH/8-1:0] s_wstrb;
    logic                    s_wvalid;
    logic                    s_wready;
    logic [1:0]              s_bresp;
    logic                    s_bvalid;
    logic                    s_bready;
    logic [ADDR_WIDTH+1:0]   s_araddr;
    logic                    s_arvalid;
    logic                    s_arready;
    logic [DATA_WIDTH-1:0]   s_rdata;
    logic [1:0]              s_rresp;
    logic                    s_rvalid;
    logic                    s_rready;
    logic                    lb_wren;
    logic [ADDR_WIDTH-1:0]   lb_waddr;
    logic [DATA_WIDTH-1:0]   lb_wdata;
    logic                    lb_rden;
    logic [ADDR_WIDTH-1:0]   lb_raddr;
    logic [DATA_WIDTH-1:0]   lb_rdata;
    logic                    lb_rvalid;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready, lb_rdata, lb_rvalid,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
        output s_rdata, s_rresp, s_rvalid,
        output lb_wren, lb_waddr, lb_wdata, lb_rden, lb_raddr
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready, lb_rdata, lb_rvalid,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
        input  s_rdata, s_rresp, s_rvalid,
        input  lb_wren, lb_waddr, lb_wdata, lb_rden, lb_raddr
    );
endinterface

// File: rtl/axil_lb_bridge.sv
// axil_lb_bridge: AXI4-Lite slave serialising one transaction at a time into local-bus strobes;
// define AXIL_LB_TIMEOUT_EN to turn a silent read responder into SLVERR after TIMEOUT cycles
import axil_lb_pkg::*;

module axil_lb_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 255
) (
    input logic              clk,
    input logic              aresetn,
    axil_lb_bridge_if.slave  bus
);
    state_t                state, state_nxt;
    logic                  last_wr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  wr_ok, rd_ok, pick_wr, pick_rd, tmo_hit, rd_done;
    logic                  unused_ok;

    assign wr_ok   = bus.s_awvalid && bus.s_wvalid;
    assign rd_ok   = bus.s_arvalid;
    assign pick_wr = wr_ok && (!rd_ok || !last_wr);
    assign pick_rd = rd_ok && !pick_wr;
    assign rd_done = state == RWAIT && (bus.lb_rvalid || tmo_hit);

`ifdef AXIL_LB_TIMEOUT_EN
    logic [15:0] cnt;

    // wait counter: zero outside RWAIT so it is clear on every entry
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) cnt <= '0;
        else          cnt <= state == RWAIT ? cnt + 16'd1 : 16'd0;
    end

    assign tmo_hit = state == RWAIT && !bus.lb_rvalid && cnt == 16'(TIMEOUT - 1);
`else
    assign tmo_hit = 1'b0;
`endif

    assign unused_ok = ^{bus.s_wstrb, bus.s_awaddr[1:0], bus.s_araddr[1:0], 32'(TIMEOUT)};

    // state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state: one outstanding transaction, alternating priority on contention
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pick_wr ? WR : pick_rd ? RD : IDLE;
            WR:      state_nxt = WRESP;
            WRESP:   state_nxt = bus.s_bready ? IDLE : WRESP;
            RD:      state_nxt = RWAIT;
            RWAIT:   state_nxt = rd_done ? RRESP : RWAIT;
            RRESP:   state_nxt = bus.s_rready ? IDLE : RRESP;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs: readies only in IDLE for the granted channel, strobes and valids from state
    always_comb begin
        bus.s_awready = state == IDLE && pick_wr;
        bus.s_wready  = state == IDLE && pick_wr;
        bus.s_arready = state == IDLE && pick_rd;
        bus.s_bvalid  = state == WRESP;
        bus.s_rvalid  = state == RRESP;
        bus.lb_wren   = state == WR;
        bus.lb_rden   = state == RD;
    end

    // datapath: latch request on accept, capture read return or timeout response
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            last_wr <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            if (state == IDLE && pick_wr) begin
                addr_q  <= bus.s_awaddr[ADDR_WIDTH+1:2];
                wdata_q <= bus.s_wdata;
                last_wr <= 1'b1;
            end else if (state == IDLE && pick_rd) begin
                addr_q  <= bus.s_araddr[ADDR_WIDTH+1:2];
                last_wr <= 1'b0;
            end
            if (state == RWAIT && bus.lb_rvalid) begin
                rdata_q <= bus.lb_rdata;
                rresp_q <= RESP_OKAY;
            end else if (tmo_hit) begin
                rdata_q <= DATA_WIDTH'(TIMEOUT_DATA);
                rresp_q <= RESP_SLVERR;
            end
        end
    end

    assign bus.s_bresp  = RESP_OKAY;
    assign bus.s_rdata  = rdata_q;
    assign bus.s_rresp  = rresp_q;
    assign bus.lb_waddr = addr_q;
    assign bus.lb_raddr = addr_q;
    assign bus.lb_wdata = wdata_q;
endmodule

// File: tb/tb_axil_lb_bridge.sv
// tb_axil_lb_bridge: directed checks of the AXI-Lite to local-bus bridge
module tb_axil_lb_bridge;
    logic clk = 1'b0;
    logic aresetn;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    axil_lb_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

    axil_lb_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT(8)) dut (
        .clk(clk),
        .aresetn(aresetn),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_outs(input string tag);
        chk({tag, "_flags"}, {25'd0, bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid,
                              bus.s_rvalid, bus.lb_wren, bus.lb_rden}, 32'd0);
        chk({tag, "_resp"}, {28'd0, bus.s_bresp, bus.s_rresp}, 32'd0);
        chk({tag, "_rdata"}, bus.s_rdata, 32'd0);
        chk({tag, "_addr"}, {12'd0, bus.lb_waddr, bus.lb_raddr}, 32'd0);
        chk({tag, "_wdata"}, bus.lb_wdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] ord;
        logic seen;
        aresetn = 1'b0;
        bus.s_awaddr = '0; bus.s_awvalid = 0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wvalid = 0;
        bus.s_bready = 0; bus.s_araddr = '0; bus.s_arvalid = 0; bus.s_rready = 0;
        bus.lb_rdata = '0; bus.lb_rvalid = 0;
        step(); step();
        zero_outs("reset");
        aresetn = 1'b1;
        step();

        // write: AW 0x010, W 0x12345678
        bus.s_awaddr = 12'h010; bus.s_wdata = 32'h12345678; bus.s_wstrb = 4'hF;
        bus.s_awvalid = 1; bus.s_wvalid = 1;
        #1;
        chk("wr_accept_ready", {29'd0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'b110);
        step();
        bus.s_awvalid = 0; bus.s_wvalid = 0;
        chk("wr_lb_wren", {31'd0, bus.lb_wren}, 32'd1);
        chk("wr_lb_waddr", {22'd0, bus.lb_waddr}, 32'd4);
        chk("wr_lb_wdata", bus.lb_wdata, 32'h12345678);
        chk("wr_ready_drop", {30'd0, bus.s_awready, bus.s_wready}, 32'd0);
        step();
        chk("wr_wren_once", {31'd0, bus.lb_wren}, 32'd0);
        chk("wr_bvalid_t2", {31'd0, bus.s_bvalid}, 32'd1);
        chk("wr_bresp", {30'd0, bus.s_bresp}, 32'd0);
        step(); step();
        chk("wr_bvalid_held", {31'd0, bus.s_bvalid}, 32'd1);
        bus.s_bready = 1;
        step();
        bus.s_bready = 0;
        chk("wr_bvalid_done", {31'd0, bus.s_bvalid}, 32'd0);

        // read: AR 0xFFC, responder answers 3 cycles after lb_rden
        bus.s_araddr = 12'hFFC; bus.s_arvalid = 1;
        #1;
        chk("rd_arready", {31'd0, bus.s_arready}, 32'd1);
        step();
        bus.s_arvalid = 0;
        chk("rd_lb_rden", {31'd0, bus.lb_rden}, 32'd1);
        chk("rd_lb_raddr", {22'd0, bus.lb_raddr}, 32'h3FF);
        step();
        chk("rd_rden_once", {31'd0, bus.lb_rden}, 32'd0);
        step(); step();
        bus.lb_rvalid = 1; bus.lb_rdata = 32'hCAFEF00D;
        chk("rd_rvalid_early", {31'd0, bus.s_rvalid}, 32'd0);
        step();
        bus.lb_rvalid = 0; bus.lb_rdata = '0;
        chk("rd_rvalid", {31'd0, bus.s_rvalid}, 32'd1);
        chk("rd_rdata", bus.s_rdata, 32'hCAFEF00D);
        chk("rd_rresp", {30'd0, bus.s_rresp}, 32'd0);
        step();
        chk("rd_rdata_held", bus.s_rdata, 32'hCAFEF00D);
        bus.s_rready = 1;
        step();
        bus.s_rready = 0;
        chk("rd_rvalid_done", {31'd0, bus.s_rvalid}, 32'd0);

        // contention: write and read both valid, responder always returning
        bus.lb_rvalid = 1; bus.lb_rdata = 32'h5A5A0001;
        bus.s_bready = 1; bus.s_rready = 1;
        bus.s_awaddr = 12'h020; bus.s_wdata = 32'hA5A5A5A5; bus.s_araddr = 12'h030;
        bus.s_awvalid = 1; bus.s_wvalid = 1; bus.s_arvalid = 1;
        n = 0; ord = '0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            step();
            if (bus.lb_wren) begin ord[n] = 1'b1; n++; end
            if (bus.lb_rden) begin ord[n] = 1'b0; n++; end
            if (n == 4) begin bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0; end
        end
        bus.s_awvalid = 0; bus.s_wvalid = 0; bus.s_arvalid = 0;
        chk("cont_count", n, 32'd4);
        chk("cont_order", {28'd0, ord}, 32'b0101);
        repeat (4) step();
        chk("cont_rdata", bus.s_rdata, 32'h5A5A0001);
        chk("cont_idle", {30'd0, bus.s_bvalid, bus.s_rvalid}, 32'd0);
        bus.lb_rvalid = 0; bus.lb_rdata = '0; bus.s_bready = 0; bus.s_rready = 0;

        // lone AW with no W for 10 cycles
        bus.s_awaddr = 12'h040; bus.s_awvalid = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.s_awready || bus.s_wready || bus.lb_wren) seen = 1;
            step();
        end
        bus.s_awvalid = 0;
        chk("lone_aw_ignored", {31'd0, seen}, 32'd0);

`ifdef AXIL_LB_TIMEOUT_EN
        // silent responder with TIMEOUT 8
        bus.s_araddr = 12'h008; bus.s_arvalid = 1;
        step();
        bus.s_arvalid = 0;
        chk("tmo_rden", {31'd0, bus.lb_rden}, 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.s_rvalid) seen = 1;
        end
        chk("tmo_no_early_rvalid", {31'd0, seen}, 32'd0);
        step();
        chk("tmo_rvalid", {31'd0, bus.s_rvalid}, 32'd1);
        chk("tmo_rresp", {30'd0, bus.s_rresp}, 32'b10);
        chk("tmo_rdata", bus.s_rdata, 32'hDEADBEEF);
        bus.lb_rvalid = 1; bus.lb_rdata = 32'h11111111;
        step();
        chk("tmo_late_rdata", bus.s_rdata, 32'hDEADBEEF);
        chk("tmo_late_rresp", {30'd0, bus.s_rresp}, 32'b10);
        bus.s_rready = 1;
        step();
        bus.s_rready = 0;
        step();
        chk("tmo_late_no_beat", {30'd0, bus.s_rvalid, bus.lb_rden}, 32'd0);
        bus.lb_rvalid = 0; bus.lb_rdata = '0;
`endif

        // reset pulsed during RWAIT
        bus.s_araddr = 12'h00C; bus.s_arvalid = 1;
        step();
        bus.s_arvalid = 0;
        step(); step();
        aresetn = 0;
        #1;
        zero_outs("midrst");
        step(); step();
        aresetn = 1;
        bus.lb_rvalid = 1; bus.lb_rdata = 32'h77777777;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.s_rvalid || bus.lb_rden) seen = 1;
        end
        chk("midrst_no_rbeat", {31'd0, seen}, 32'd0);
        bus.lb_rvalid = 0; bus.lb_rdata = '0;
        bus.s_araddr = 12'h044; bus.s_arvalid = 1;
        #1;
        chk("post_rst_arready", {31'd0, bus.s_arready}, 32'd1);
        step();
        bus.s_arvalid = 0;
        chk("post_rst_raddr", {22'd0, bus.lb_raddr}, 32'h011);
        step();
        bus.lb_rvalid = 1; bus.lb_rdata = 32'h0BADF00D;
        step();
        bus.lb_rvalid = 0; bus.lb_rdata = '0;
        chk("post_rst_rvalid", {31'd0, bus.s_rvalid}, 32'd1);
        chk("post_rst_rdata", bus.s_rdata, 32'h0BADF00D);
        chk("post_rst_rresp", {30'd0, bus.s_rresp}, 32'd0);
        bus.s_rready = 1;
        step();
        bus.s_rready = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/axil_lb_bridge.md
# axil_lb_bridge

- AXI4-Lite slave to local-bus initiator: the master that drives the register local bus (`lb1`/`lb2` class responders, `ifregs`/`ifdspregs`) from the PS AXI port.
- Serialises AXI reads and writes into single-cycle local-bus strobes and returns AXI responses.
- One instance sits per register bank, between the PS interconnect and the pltop local-bus port.
- An optional read timeout turns a silent responder into an AXI error.

## Interface
- `DATA_WIDTH`, 32: data width of the AXI and local-bus paths.
- `ADDR_WIDTH`, 10: local-bus word-address width. The AXI byte address is `ADDR_WIDTH+2` bits.
- `TIMEOUT`, 255: read-wait limit in cycles. Range 1..65535. Used only with `AXIL_LB_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock. All I/O is synchronous to it.
- `aresetn` in 1: asynchronous, active-low reset, synchronously released upstream.
- `s_awaddr` in ADDR_WIDTH+2, `s_awvalid` in 1, `s_awready` out 1: write-address channel.
- `s_wdata` in DATA_WIDTH, `s_wstrb` in DATA_WIDTH/8, `s_wvalid` in 1, `s_wready` out 1: write-data channel. `s_wstrb` is ignored; writes are always full-word.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1: write-response channel.
- `s_araddr` in ADDR_WIDTH+2, `s_arvalid` in 1, `s_arready` out 1: read-address channel.
- `s_rdata` out DATA_WIDTH, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1: read-data channel.
- `lb_wren` out 1, `lb_waddr` out ADDR_WIDTH, `lb_wdata` out DATA_WIDTH: local-bus write strobe, address and data.
- `lb_rden` out 1, `lb_raddr` out ADDR_WIDTH: local-bus read strobe and address.
- `lb_rdata` in DATA_WIDTH, `lb_rvalid` in 1: local-bus read return.

## Operation
- States: IDLE, WR, WRESP, RD, RWAIT, RRESP.
- Only one transaction is outstanding at a time; there is no pipelining.
- IDLE, write eligible: `s_awvalid && s_wvalid`. A lone AW or a lone W is never accepted.
- IDLE, read eligible: `s_arvalid`.
- Write and read both eligible in the same cycle: serve the one not served last, tracked by flop `last_wr` (reset 0, so the write wins first). This rule removes starvation.
- Write accept: `s_awready` and `s_wready` are high together for 1 cycle. Latch address bits [ADDR_WIDTH+1:2] and the data. Go to WR.
- WR: `lb_wren` = 1 for exactly 1 cycle, then go to WRESP.
- WRESP: `s_bvalid` = 1 with `s_bresp` = 00. Hold until `s_bready`, then go to IDLE.
- Read accept: `s_arready` is high for 1 cycle. Latch the address. Go to RD.
- RD: `lb_rden` = 1 for exactly 1 cycle, then go to RWAIT.
- RWAIT: on `lb_rvalid`, capture `lb_rdata`, set `s_rresp` = 00 and go to RRESP.
- RRESP: `s_rvalid` = 1. Hold data and response stable until `s_rready`, then go to IDLE.
- `lb_rvalid` arriving outside RWAIT is ignored, including late or duplicate returns.
- Reset mid-transaction aborts the transaction: no local-bus strobe and no AXI response are issued for it.

## Timing
- Reset values: every output 0, including all readies, strobes, addresses, `s_rdata` and responses. State is IDLE.
- Write accepted at cycle t:
  - `lb_wren` high at t+1.
  - `s_bvalid` high from t+2.
  - Next acceptance no earlier than the cycle after the B handshake.
- Read accepted at cycle t:
  - `lb_rden` high at t+1.
  - `lb_rvalid` is sampled from t+2 onward.
  - `lb_rvalid` seen at cycle u gives `s_rvalid` high at u+1.
- Readies are asserted only in IDLE, and only for the channel being accepted.
- Readies do not depend combinationally on `s_bready` or `s_rready`.

## Configuration
- Macro `AXIL_LB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to RWAIT and increments each RWAIT cycle.
  - When the count reaches `TIMEOUT` with no `lb_rvalid`, go to RRESP with `s_rresp` = 10 (SLVERR) and `s_rdata` = 32'hDEADBEEF, truncated to DATA_WIDTH.
  - If `lb_rvalid` arrives in the same cycle the limit is hit, `lb_rvalid` wins and the response is OKAY.
- Undefined: no counter. RWAIT waits indefinitely.

## Structure
- Package `axil_lb_pkg` holds:
  - the state enum;
  - the `RESP_OKAY`/`RESP_SLVERR` constants;
  - the `TIMEOUT_DATA` constant (32'hDEADBEEF).
- Single module with no sub-modules.
- The arbitration flop and the timeout counter live inline.

## Test plan
- Write: AW = 0x010 and W = 0x12345678 presented together. Expect:
  - `lb_wren` 1 cycle with `lb_waddr` = 4 and `lb_wdata` = 0x12345678;
  - `s_bresp` 00;
  - B held 3 cycles while `s_bready` = 0.
- Read: AR = 0xFFC. Responder returns 0xCAFEF00D 3 cycles after `lb_rden`. Expect `lb_raddr` = 0x3FF and `s_rdata` = 0xCAFEF00D with OKAY.
- Contention: AW+W and AR held valid together for 4 transactions. Expect the order write, read, write, read.
- Lone AW held 10 cycles with no W. Expect `s_awready` to stay 0 and no `lb_wren`.
- Timeout (macro on, `TIMEOUT` = 8): responder silent. Expect `s_rvalid` 9 cycles after `lb_rden` with SLVERR and 0xDEADBEEF. Then inject a late `lb_rvalid` and expect it to be ignored.
- `aresetn` pulsed during RWAIT. Expect all outputs 0 immediately, no R beat, and a fresh read to succeed afterwards.
